// File: rtl/all_gates_pkg.sv
// Shared constants for the two-input gate bank: result width and the bit
// position of each gate function inside the result vector.
package all_gates_pkg;

  localparam int RES_W = 6;

  localparam int IDX_AND  = 0;
  localparam int IDX_OR   = 1;
  localparam int IDX_NAND = 2;
  localparam int IDX_NOR  = 3;
  localparam int IDX_XOR  = 4;
  localparam int IDX_XNOR = 5;

  localparam int CNT_W_MIN = 2;
  localparam int CNT_W_MAX = 16;

endpackage

// File: rtl/all_gates_gate_bank.sv
// Purely combinational evaluation of the six two-input gate functions.
module gate_bank
  import all_gates_pkg::*;
(
  input  logic             a,
  input  logic             b,
  output logic [RES_W-1:0] res
);

  assign res[IDX_AND]  =   a & b;
  assign res[IDX_OR]   =   a | b;
  assign res[IDX_NAND] = ~(a & b);
  assign res[IDX_NOR]  = ~(a | b);
  assign res[IDX_XOR]  =   a ^ b;
  assign res[IDX_XNOR] = ~(a ^ b);

endmodule

// File: rtl/all_gates.sv
// Registers the gate-bank result on enabled edges, flags the first capture
// and keeps a saturating count of captures that altered the result.
module all_gates
  import all_gates_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  output logic [RES_W-1:0] ot,
  output logic             ot_valid,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("all_gates: CNT_W out of range");
  end

  logic [RES_W-1:0] gate_vec;
  logic             vec_changed;

  gate_bank u_gate_bank (
    .a   (a),
    .b   (b),
    .res (gate_vec)
  );

  // Reset value 0 never matches a gate vector, so the first capture counts.
  assign vec_changed = (gate_vec != ot);

  always_ff @(posedge clk) begin
    if (rst) begin
      ot       <= '0;
      ot_valid <= 1'b0;
      chg_cnt  <= '0;
    end else if (en) begin
      ot       <= gate_vec;
      ot_valid <= 1'b1;
      if (vec_changed && chg_cnt != CNT_MAX) begin
        chg_cnt <= chg_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_all_gates.sv
// Bench for all_gates: truth-table reference model, per-cycle compare, and
// literal checks of the directed sequences; a CNT_W=2 copy covers saturation.
module tb_all_gates;

  logic       clk;
  logic       rst;
  logic       en;
  logic       a;
  logic       b;
  logic [5:0] ot;
  logic       ot_valid;
  logic [7:0] chg_cnt;
  logic [5:0] ot2;
  logic       ot_valid2;
  logic [1:0] chg_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  all_gates #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .ot(ot), .ot_valid(ot_valid), .chg_cnt(chg_cnt)
  );

  all_gates #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .ot(ot2), .ot_valid(ot_valid2), .chg_cnt(chg_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truth table indexed by {a,b}, unbounded change count.
  logic [5:0] tt [4];
  initial begin
    tt[0] = 6'b101100;
    tt[1] = 6'b010110;
    tt[2] = 6'b010110;
    tt[3] = 6'b100011;
  end

  logic [5:0] m_ot;
  logic       m_valid;
  int         m_chg;
  bit         chk_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ot    = 6'd0;
      m_valid = 1'b0;
      m_chg   = 0;
      chk_on  = 1'b1;
    end else if (en) begin
      if (tt[{a, b}] != m_ot) m_chg = m_chg + 1;
      m_ot    = tt[{a, b}];
      m_valid = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("ot", {26'd0, ot}, {26'd0, m_ot});
      check("ot_valid", {31'd0, ot_valid}, {31'd0, m_valid});
      check("chg_cnt", {24'd0, chg_cnt}, sat(m_chg, 8));
      check("ot_w2", {26'd0, ot2}, {26'd0, m_ot});
      check("chg_cnt_w2", {30'd0, chg_cnt2}, sat(m_chg, 2));
      if (ot_valid) begin
        check("inv_nand", {31'd0, ot[2]}, {31'd0, ~ot[0]});
        check("inv_nor", {31'd0, ot[3]}, {31'd0, ~ot[1]});
        check("inv_xnor", {31'd0, ot[5]}, {31'd0, ~ot[4]});
      end
    end
  end

  task automatic cyc(input logic r, input logic e, input logic aa, input logic bb);
    rst = r; en = e; a = aa; b = bb;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; a = 1'b0; b = 1'b0;

    cyc(1, 0, 0, 0);
    check("lit_rst_ot", {26'd0, ot}, 32'h00);
    check("lit_rst_valid", {31'd0, ot_valid}, 32'd0);
    check("lit_rst_cnt", {24'd0, chg_cnt}, 32'd0);

    cyc(0, 1, 0, 0);
    check("lit_00_ot", {26'd0, ot}, 32'b101100);
    check("lit_00_valid", {31'd0, ot_valid}, 32'd1);
    check("lit_00_cnt", {24'd0, chg_cnt}, 32'd1);

    cyc(0, 1, 0, 1);
    check("lit_01_ot", {26'd0, ot}, 32'b010110);
    cyc(0, 1, 1, 0);
    check("lit_10_ot", {26'd0, ot}, 32'b010110);
    check("lit_10_cnt", {24'd0, chg_cnt}, 32'd2);
    cyc(0, 1, 1, 1);
    check("lit_11_ot", {26'd0, ot}, 32'b100011);
    check("lit_11_cnt", {24'd0, chg_cnt}, 32'd3);

    for (int i = 0; i < 5; i++) cyc(0, 0, 1'($urandom), 1'($urandom));
    check("lit_hold_ot", {26'd0, ot}, 32'b100011);
    check("lit_hold_valid", {31'd0, ot_valid}, 32'd1);
    check("lit_hold_cnt", {24'd0, chg_cnt}, 32'd3);

    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, i[0], i[0]);
    check("lit_sat_cnt_w2", {30'd0, chg_cnt2}, 32'd3);
    check("lit_sat_cnt_w8", {24'd0, chg_cnt}, 32'd10);

    cyc(1, 1, 1, 1);
    check("lit_rstpri_ot", {26'd0, ot}, 32'd0);
    check("lit_rstpri_valid", {31'd0, ot_valid}, 32'd0);
    check("lit_rstpri_cnt", {24'd0, chg_cnt}, 32'd0);
    check("lit_rstpri_cnt_w2", {30'd0, chg_cnt2}, 32'd0);

    for (int i = 0; i < 1000; i++) begin
      cyc(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/all_gates.md
ALL_GATES -- requirements
Module: all_gates

Interface
REQ-001 Parameter CNT_W, default 8, width of the output-change counter; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  capture enable; when 1 the gate results of a/b are registered this cycle.
REQ-005 a  input  1  first operand.
REQ-006 b  input  1  second operand.
REQ-007 ot  output  6  registered gate results: bit0 AND, bit1 OR, bit2 NAND, bit3 NOR, bit4 XOR, bit5 XNOR.
REQ-008 ot_valid  output  1  high once at least one capture has occurred since reset.
REQ-009 chg_cnt  output  CNT_W  saturating count of captures that changed ot.

Function
REQ-010 The block SHALL compute the six two-input functions of a and b combinationally, with bit mapping per REQ-007.
REQ-011 On a rising clk edge with rst=0 and en=1, ot SHALL load the computed vector; latency from a/b to ot is exactly one cycle.
REQ-012 With rst=0 and en=0, ot SHALL hold its value.
REQ-013 ot_valid SHALL go high on the edge of the first capture after reset and stay high until the next reset.
REQ-014 chg_cnt SHALL increment by 1 on a capture edge whose computed vector differs from the current ot; a capture with an identical vector leaves it unchanged.
REQ-015 The first capture after reset SHALL count as a change, because every computed vector differs from the reset value 6'b000000.
REQ-016 chg_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-017 Outputs SHALL depend only on registered state; no combinational path from inputs to outputs.
REQ-018 Invariants: ot[2]=~ot[0], ot[3]=~ot[1] and ot[5]=~ot[4] whenever ot_valid=1.

Reset
REQ-019 rst=1 at a rising edge SHALL force ot=6'b000000, ot_valid=0 and chg_cnt=0, regardless of en, a or b.
REQ-020 Reset SHALL take priority over capture in the same cycle.
REQ-021 Reset asserted mid-operation SHALL clear state on the next edge, with no residual count.

Structure
REQ-022 Package all_gates_pkg SHALL hold the bit-index constants (IDX_AND=0 through IDX_XNOR=5) and the 6-bit result width.
REQ-023 The combinational gate evaluation SHALL reside in one sub-module, gate_bank (inputs a and b, output 6-bit vector).
REQ-024 all_gates SHALL contain the result register, the valid flag and the counter.

Verification
REQ-025 Reset, then en=1 with a=0,b=0 for one cycle -> ot=6'b101100, ot_valid=1, chg_cnt=1.
REQ-026 Sequence a/b = 01, 10, 11 with en=1, one per cycle -> ot=6'b010110, 6'b010110, 6'b100011; chg_cnt ends at 3 (01->10 is not a change).
REQ-027 en=0 while a/b toggle for 5 cycles -> ot, ot_valid and chg_cnt are unchanged.
REQ-028 CNT_W=2 with alternating a/b 00/11 and en=1 for 10 cycles -> chg_cnt saturates at 3.
REQ-029 rst=1 and en=1 in the same cycle with a=1,b=1 -> ot=0, ot_valid=0, chg_cnt=0.
REQ-030 Random a/b/en for 1000 cycles -> ot matches the reference gate model delayed one capture, and the REQ-018 invariants hold.
